// File: rtl/matrix_pkg.sv
// Shared matrix-calculator constants and the C-readout streamer state encoding.
package matrix_pkg;

  localparam int unsigned MAT_ADDR_W  = 10;
  localparam int unsigned MAT_DATA_W  = 8;
  localparam int unsigned MAT_N_WORDS = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT_IDLE,
    GUARD,
    WAIT_TX,
    CSUM,
    FINISH
  } c_readout_state_t;

endpackage

// File: rtl/c_readout_csum.sv
// Modulo-2^DATA_W running sum of streamed bytes; only used when C_READOUT_CHECKSUM_EN is defined.
module c_readout_csum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/c_readout_streamer.sv
// Streams result memory C (addresses 0..N_WORDS-1) into the UART transmitter with a valid/busy handshake.
// Optional trailing checksum byte when C_READOUT_CHECKSUM_EN is defined.
module c_readout_streamer
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_W    = MAT_ADDR_W,
  parameter int unsigned DATA_W    = MAT_DATA_W,
  parameter int unsigned N_WORDS   = MAT_N_WORDS,
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              finish,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              active,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  c_readout_state_t  state, state_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic              valid_nx;
  logic [3:0]        guard, guard_nx;

`ifdef C_READOUT_CHECKSUM_EN
  logic              csum_sent, csum_sent_nx;
  logic              csum_clr, csum_add;
  logic [DATA_W-1:0] csum;

  c_readout_csum #(.DATA_W(DATA_W)) u_csum (
    .clk (clk),
    .rst (rst),
    .clr (csum_clr),
    .add (csum_add),
    .din (tx_data),
    .sum (csum)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      guard    <= '0;
`ifdef C_READOUT_CHECKSUM_EN
      csum_sent <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      mem_addr <= addr_nx;
      tx_data  <= data_nx;
      tx_valid <= valid_nx;
      guard    <= guard_nx;
`ifdef C_READOUT_CHECKSUM_EN
      csum_sent <= csum_sent_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = mem_addr;
    data_nx  = tx_data;
    valid_nx = 1'b0;
    guard_nx = guard;
`ifdef C_READOUT_CHECKSUM_EN
    csum_sent_nx = csum_sent;
    csum_clr     = 1'b0;
    csum_add     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (finish) begin
          state_nx = FETCH;
          addr_nx  = '0;
`ifdef C_READOUT_CHECKSUM_EN
          csum_clr     = 1'b1;
          csum_sent_nx = 1'b0;
`endif
        end
      end
      FETCH: state_nx = LATCH;
      LATCH: begin
        data_nx  = mem_dout;
        state_nx = WAIT_IDLE;
      end
      // The strobe is registered, so it appears the cycle after busy is seen low.
      WAIT_IDLE: begin
        if (!tx_busy) begin
          valid_nx = 1'b1;
          guard_nx = 4'(GUARD_CYC);
          state_nx = GUARD;
`ifdef C_READOUT_CHECKSUM_EN
          csum_add = !csum_sent;
`endif
        end
      end
      GUARD: begin
        guard_nx = guard - 4'd1;
        if (guard <= 4'd1) state_nx = WAIT_TX;
      end
      WAIT_TX: begin
        if (!tx_busy) begin
`ifdef C_READOUT_CHECKSUM_EN
          if (csum_sent) begin
            state_nx = FINISH;
          end else if (mem_addr == LAST_ADDR) begin
            state_nx = CSUM;
          end else begin
            addr_nx  = mem_addr + ADDR_W'(1);
            state_nx = FETCH;
          end
`else
          if (mem_addr == LAST_ADDR) begin
            state_nx = FINISH;
          end else begin
            addr_nx  = mem_addr + ADDR_W'(1);
            state_nx = FETCH;
          end
`endif
        end
      end
`ifdef C_READOUT_CHECKSUM_EN
      CSUM: begin
        data_nx      = csum;
        csum_sent_nx = 1'b1;
        state_nx     = WAIT_IDLE;
      end
`endif
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done   = (state == FINISH);
  assign active = (state != IDLE);

endmodule

// File: tb/tb_c_readout_streamer.sv
// Two streamers (4-word and 1024-word) driven by randomized stimulus and checked every cycle
// against a timing model derived from the handshake rules.
module tb_c_readout_streamer;

`ifdef C_READOUT_CHECKSUM_EN
  localparam int CSN = 1;
`else
  localparam int CSN = 0;
`endif
  localparam int G0 = 2;
  localparam int G1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_v[2], fin_v[2], valid_v[2], busy_v[2], act_v[2], done_v[2];
  logic       force_v[2], noise_v[2];
  bit         noise_en[2];
  logic [9:0] addr_v[2];
  logic [7:0] dout_v[2], data_v[2];
  logic [7:0] mem_s[4];
  logic [7:0] mem_f[1024];
  int         frame_len[2], bcnt[2];

  c_readout_streamer #(.ADDR_W(10), .DATA_W(8), .N_WORDS(4), .GUARD_CYC(G0)) dut_s (
    .clk(clk), .rst(rst_v[0]), .finish(fin_v[0]), .mem_addr(addr_v[0]), .mem_dout(dout_v[0]),
    .tx_data(data_v[0]), .tx_valid(valid_v[0]), .tx_busy(busy_v[0]), .active(act_v[0]), .done(done_v[0]));

  c_readout_streamer #(.ADDR_W(10), .DATA_W(8), .N_WORDS(1024), .GUARD_CYC(G1)) dut_f (
    .clk(clk), .rst(rst_v[1]), .finish(fin_v[1]), .mem_addr(addr_v[1]), .mem_dout(dout_v[1]),
    .tx_data(data_v[1]), .tx_valid(valid_v[1]), .tx_busy(busy_v[1]), .active(act_v[1]), .done(done_v[1]));

  // memory C port B (1-cycle read latency) and a transmitter that is busy for frame_len cycles
  always @(posedge clk) begin
    dout_v[0] <= (addr_v[0] < 10'd4) ? mem_s[addr_v[0] % 4] : 8'hEE;
    dout_v[1] <= mem_f[addr_v[1]];
    for (int k = 0; k < 2; k++) begin
      if (valid_v[k] === 1'b1) bcnt[k] <= frame_len[k];
      else if (bcnt[k] > 0) bcnt[k] <= bcnt[k] - 1;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) noise_v[k] = noise_en[k] && ($urandom_range(3) == 0);
  end

  assign busy_v[0] = (bcnt[0] != 0) | force_v[0] | noise_v[0];
  assign busy_v[1] = (bcnt[1] != 0) | force_v[1] | noise_v[1];

  int n_cmp = 0, n_bad = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] memval(input int k, input int i);
    if (k == 0) return (i < 4) ? mem_s[i % 4] : 8'hEE;
    return mem_f[i % 1024];
  endfunction

  // model: cycle numbers at which each future event is due (-1 = not pending)
  int         nw[2] = '{4, 1024};
  int         gc[2] = '{G0, G1};
  int         wi[2], wt[2], sat[2], dat[2], rchk[2], idx[2];
  bit         eact[2];
  logic [7:0] esum[2];

  int         scnt[2], dcnt[2], first_cyc[2], done_cyc[2], fall_cyc[2];
  logic [7:0] last_data[2];
  logic [9:0] last_addr[2];
  logic [7:0] log_s[8];

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        int n, len;
        bit nact;
        logic [7:0] eb;
        logic [9:0] ea;
        n   = cyc;
        len = nw[k] + CSN;
        chk("tx_valid", {31'b0, valid_v[k]}, {31'b0, sat[k] == n});
        chk("done", {31'b0, done_v[k]}, {31'b0, dat[k] == n});
        chk("active", {31'b0, act_v[k]}, {31'b0, eact[k]});
        if (valid_v[k] === 1'b1) chk("strobe_while_busy", {31'b0, bcnt[k] != 0}, 32'd0);
        if (sat[k] == n) begin
          if (idx[k] >= len) eb = 8'hEE;
          else if (idx[k] < nw[k]) eb = memval(k, idx[k]);
          else eb = esum[k];
          ea = (idx[k] < nw[k]) ? 10'(idx[k]) : 10'(nw[k] - 1);
          chk("tx_data", {24'b0, data_v[k]}, {24'b0, eb});
          chk("mem_addr", {22'b0, addr_v[k]}, {22'b0, ea});
          idx[k]++;
        end
        if (rchk[k] == n) begin
          chk("rst_addr", {22'b0, addr_v[k]}, 32'd0);
          chk("rst_data", {24'b0, data_v[k]}, 32'd0);
        end
        if (valid_v[k] === 1'b1) begin
          if (scnt[k] == 0) first_cyc[k] = n;
          if (k == 0 && scnt[0] < 8) log_s[scnt[0]] = data_v[0];
          scnt[k]++;
          last_data[k] = data_v[k];
          last_addr[k] = addr_v[k];
        end
        if (done_v[k] === 1'b1) begin
          dcnt[k]++;
          done_cyc[k] = n;
        end
        if (act_v[k] === 1'b0 && fall_cyc[k] < 0 && done_cyc[k] >= 0) fall_cyc[k] = n;

        nact = eact[k];
        if (rst_v[k]) begin
          nact = 0; wi[k] = -1; wt[k] = -1; sat[k] = -1; dat[k] = -1; rchk[k] = n + 1;
        end else begin
          if (!eact[k] && fin_v[k]) begin
            nact = 1; wi[k] = n + 3; idx[k] = 0; esum[k] = 8'h00;
            for (int i = 0; i < nw[k]; i++) esum[k] = esum[k] + memval(k, i);
          end
          if (wi[k] >= 0 && n >= wi[k] && !busy_v[k]) begin
            sat[k] = n + 1; wt[k] = n + 1 + gc[k]; wi[k] = -1;
          end
          if (wt[k] >= 0 && n >= wt[k] && !busy_v[k]) begin
            wt[k] = -1;
            if (idx[k] < len) wi[k] = (idx[k] == nw[k]) ? n + 2 : n + 3;
            else dat[k] = n + 1;
          end
          if (dat[k] == n) nact = 0;
        end
        eact[k] = nact;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int k);
    fin_v[k] = 1'b1;
    tick();
    fin_v[k] = 1'b0;
  endtask

  task automatic clear_stats(input int k);
    scnt[k] = 0; dcnt[k] = 0; first_cyc[k] = -1; done_cyc[k] = -1; fall_cyc[k] = -1;
  endtask

  task automatic wait_done(input int k, input int budget, input string name);
    int b = 0;
    while (dcnt[k] == 0 && b < budget) begin tick(); b++; end
    if (dcnt[k] == 0) chk(name, 32'(dcnt[k]), 32'd1);
  endtask

  task automatic wait_strobes(input int k, input int target, input int budget, input string name);
    int b = 0;
    while (scnt[k] < target && b < budget) begin tick(); b++; end
    if (scnt[k] < target) chk(name, 32'(scnt[k]), 32'(target));
  endtask

  logic [7:0] basic_bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int rel;
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; fin_v[k] = 1'b0; force_v[k] = 1'b0; noise_en[k] = 0; frame_len[k] = 20;
      bcnt[k] = 0; wi[k] = -1; wt[k] = -1; sat[k] = -1; dat[k] = -1; rchk[k] = -1; idx[k] = 0;
      eact[k] = 0; esum[k] = 8'h00;
      clear_stats(k);
    end
    for (int i = 0; i < 4; i++) mem_s[i] = basic_bytes[i];
    for (int i = 0; i < 1024; i++) mem_f[i] = 8'(i);

    repeat (2) @(posedge clk);
    #1 mon_en = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_addr", {22'b0, addr_v[k]}, 32'd0);
      chk("reset_data", {24'b0, data_v[k]}, 32'd0);
      chk("reset_valid", {31'b0, valid_v[k]}, 32'd0);
      chk("reset_active", {31'b0, act_v[k]}, 32'd0);
      chk("reset_done", {31'b0, done_v[k]}, 32'd0);
    end
    @(posedge clk); #1;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    tick();

    // basic stream
    clear_stats(0);
    start(0);
    wait_done(0, 800, "basic_timeout");
    repeat (3) tick();
    chk("basic_count", 32'(scnt[0]), 32'(4 + CSN));
    for (int i = 0; i < 4; i++) chk("basic_byte", {24'b0, log_s[i]}, {24'b0, basic_bytes[i]});
    chk("basic_done_once", 32'(dcnt[0]), 32'd1);
    chk("basic_active_fall", 32'(fall_cyc[0] - done_cyc[0]), 32'd1);
`ifdef C_READOUT_CHECKSUM_EN
    chk("csum_byte", {24'b0, log_s[4]}, 32'h0000_00AA);
`endif

    // finish re-pulsed while streaming is ignored
    clear_stats(0);
    start(0);
    wait_strobes(0, 2, 400, "refinish_timeout");
    start(0);
    wait_done(0, 800, "refinish_done_timeout");
    repeat (3) tick();
    chk("refinish_count", 32'(scnt[0]), 32'(4 + CSN));
    chk("refinish_done_once", 32'(dcnt[0]), 32'd1);

    // busy stall before the first byte
    clear_stats(0);
    force_v[0] = 1'b1;
    start(0);
    repeat (100) tick();
    chk("stall_quiet", 32'(scnt[0]), 32'd0);
    force_v[0] = 1'b0;
    rel = cyc;
    wait_done(0, 800, "stall_timeout");
    repeat (3) tick();
    chk("stall_latency", 32'(first_cyc[0] - rel), 32'd1);
    chk("stall_first_byte", {24'b0, log_s[0]}, 32'h0000_0011);

    // reset at byte 37, then full-depth stream
    frame_len[1] = 8;
    clear_stats(1);
    start(1);
    wait_strobes(1, 37, 5000, "mrst_timeout");
    rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0;
    @(negedge clk);
    chk("mrst_valid", {31'b0, valid_v[1]}, 32'd0);
    chk("mrst_active", {31'b0, act_v[1]}, 32'd0);
    chk("mrst_addr", {22'b0, addr_v[1]}, 32'd0);
    @(posedge clk); #1;
    clear_stats(1);
    start(1);
    wait_done(1, 40000, "full_timeout");
    repeat (3) tick();
    chk("full_count", 32'(scnt[1]), 32'(1024 + CSN));
    chk("full_last_addr", {22'b0, last_addr[1]}, 32'h0000_03FF);
`ifdef C_READOUT_CHECKSUM_EN
    chk("full_last_data", {24'b0, last_data[1]}, 32'h0000_0000);
`else
    chk("full_last_data", {24'b0, last_data[1]}, 32'h0000_00FF);
`endif
    chk("full_done_once", 32'(dcnt[1]), 32'd1);

    // randomized runs: random data, frame lengths, spurious busy, finish spam and resets
    for (int r = 0; r < 30; r++) begin
      int b, rst_at;
      bit do_rst;
      for (int i = 0; i < 4; i++) mem_s[i] = 8'($urandom);
      frame_len[0] = $urandom_range(25);
      noise_en[0]  = ($urandom_range(1) == 1);
      do_rst = ($urandom_range(3) == 0);
      rst_at = $urandom_range(150, 10);
      clear_stats(0);
      start(0);
      b = 0;
      while (dcnt[0] == 0 && b < 3000) begin
        fin_v[0] = ($urandom_range(19) == 0) || (do_rst && b == rst_at + 2);
        rst_v[0] = do_rst && (b == rst_at);
        tick();
        fin_v[0] = 1'b0;
        rst_v[0] = 1'b0;
        b++;
      end
      if (dcnt[0] == 0) chk("random_timeout", 32'(dcnt[0]), 32'd1);
      repeat (2) tick();
    end
    noise_en[0] = 0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
